// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer: NUM_CHANNELS independent interval timers behind one
// Avalon-MM slave. Each channel has a STATUS/CONTROL/PERIOD/COUNT register
// quad at word base ch*4, its own prescaler, and a maskable timeout interrupt.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   address         word address {channel, reg[1:0]}
//   chipselect      slave select
//   write_n         active-low write
//   writedata       32-bit write data
//   readdata        registered read data (valid one cycle after address)
//   irq             OR of irq_vector
//   irq_vector      per-channel TO && ITO

// One timer channel: prescaler, down counter, TO/RUN flags and its registers.
module amt_channel #(
  parameter int             CW  = 32,
  parameter int             PW  = 8,
  parameter logic [CW-1:0]  DEF = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_status_i,
  input  logic          wr_control_i,
  input  logic          wr_period_i,
  input  logic [3:0]    ctrl_bits_i,   // {STOP, START, CONT, ITO}
  input  logic [PW-1:0] presc_i,
  input  logic [CW-1:0] period_i,
  output logic          to_o,
  output logic          run_o,
  output logic [3:0]    ctrl_bits_o,
  output logic [PW-1:0] presc_o,
  output logic [CW-1:0] period_o,
  output logic [CW-1:0] count_o
);
  logic          to_q, to_d, run_q, run_d;
  logic [3:0]    cbits_q;
  logic [PW-1:0] presc_q, psc_q, psc_d;
  logic [CW-1:0] period_q, cnt_q, cnt_d;
  logic          tick;

  assign tick = run_q && (psc_q == presc_q);

  // Order of overrides encodes priority: counting, then START/STOP (START
  // wins), then the PERIOD force-reload, then the STATUS clear of TO.
  always_comb begin
    psc_d = psc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    to_d  = to_q;
    if (run_q) psc_d = tick ? '0 : psc_q + 1'b1;
    if (tick) begin
      if (cnt_q == '0) begin
        cnt_d = period_q;
        to_d  = 1'b1;
        run_d = cbits_q[1];
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    if (wr_control_i) begin
      if (ctrl_bits_i[2]) begin
        run_d = 1'b1;
        psc_d = '0;
      end else if (ctrl_bits_i[3]) begin
        run_d = 1'b0;
      end
    end
    if (wr_period_i) begin
      cnt_d = period_i;
      run_d = 1'b0;
      psc_d = '0;
      to_d  = to_q;
    end
    if (wr_status_i) to_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_q     <= 1'b0;
      run_q    <= 1'b0;
      cbits_q  <= '0;
      presc_q  <= '0;
      period_q <= DEF;
      cnt_q    <= DEF;
      psc_q    <= '0;
    end else begin
      to_q  <= to_d;
      run_q <= run_d;
      cnt_q <= cnt_d;
      psc_q <= psc_d;
      if (wr_control_i) begin
        cbits_q <= ctrl_bits_i;
        presc_q <= presc_i;
      end
      if (wr_period_i) period_q <= period_i;
    end
  end

  assign to_o        = to_q;
  assign run_o       = run_q;
  assign ctrl_bits_o = cbits_q;
  assign presc_o     = presc_q;
  assign period_o    = period_q;
  assign count_o     = cnt_q;
endmodule

module avalon_multi_timer #(
  parameter int NUM_CHANNELS   = 4,
  parameter int COUNTER_WIDTH  = 32,
  parameter int DEFAULT_PERIOD = 49999,
  parameter int PRESCALE_WIDTH = 8,
  localparam int AW = $clog2(NUM_CHANNELS) + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AW-1:0]           address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic                    irq,
  output logic [NUM_CHANNELS-1:0] irq_vector
);
  localparam int CW = COUNTER_WIDTH;
  localparam int PW = PRESCALE_WIDTH;

  logic [NUM_CHANNELS-1:0]          to_w, run_w;
  logic [NUM_CHANNELS-1:0][3:0]     cbits_w;
  logic [NUM_CHANNELS-1:0][PW-1:0]  presc_w;
  logic [NUM_CHANNELS-1:0][CW-1:0]  period_w, count_w;
  logic [AW-1:0]                    ch_idx;
  logic [1:0]                       reg_sel;
  logic                             wr;
  logic [31:0]                      rd_d, readdata_q;
  logic                             unused_wd;

  // Shift rather than slice so a single-channel build (AW == 2) still works.
  assign ch_idx    = address >> 2;
  assign reg_sel   = address[1:0];
  assign wr        = chipselect && !write_n;
  assign unused_wd = ^writedata;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic sel;
    assign sel = wr && (ch_idx == AW'(c));
    amt_channel #(.CW(CW), .PW(PW), .DEF(CW'(DEFAULT_PERIOD))) u_ch (
      .clk          (clk),
      .reset        (reset),
      .wr_status_i  (sel && reg_sel == 2'd0),
      .wr_control_i (sel && reg_sel == 2'd1),
      .wr_period_i  (sel && reg_sel == 2'd2),
      .ctrl_bits_i  (writedata[3:0]),
      .presc_i      (writedata[8+PW-1:8]),
      .period_i     (writedata[CW-1:0]),
      .to_o         (to_w[c]),
      .run_o        (run_w[c]),
      .ctrl_bits_o  (cbits_w[c]),
      .presc_o      (presc_w[c]),
      .period_o     (period_w[c]),
      .count_o      (count_w[c])
    );
    assign irq_vector[c] = to_w[c] && cbits_w[c][0];
  end

  assign irq = |irq_vector;

  // Slots past NUM_CHANNELS never match and read as zero.
  always_comb begin
    rd_d = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_idx == AW'(c)) begin
        case (reg_sel)
          2'd0:    rd_d = {30'd0, run_w[c], to_w[c]};
          2'd1:    rd_d = 32'({presc_w[c], 4'b0000, cbits_w[c]});
          2'd2:    rd_d = 32'(period_w[c]);
          default: rd_d = 32'(count_w[c]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= rd_d;
  end

  assign readdata = readdata_q;
endmodule

// File: tb/tb_avalon_multi_timer.sv
module tb_avalon_multi_timer;
  localparam int NCH = 4;
  localparam int AW  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  address;
  logic           chipselect, write_n;
  logic [31:0]    writedata, readdata;
  logic           irq;
  logic [NCH-1:0] irq_vector;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  avalon_multi_timer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vector (irq_vector)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    address = AW'(ch * 4 + r); writedata = d; chipselect = 1'b1; write_n = 1'b0;
    idle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Returns the register value as it stood when the task was entered.
  task automatic rd(input int ch, input int r, output logic [31:0] d);
    address = AW'(ch * 4 + r);
    idle();
    d = readdata;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) idle();
  endtask

  // Closed-form channel state e edges after START, PRESC p, PERIOD P.
  function automatic void model(input int P, input int p, input bit cont, input int e,
                                output int cnt, output bit to, output bit run);
    int t;
    t = e / (p + 1);
    if (!cont && t >= P + 1) begin
      cnt = P; to = 1'b1; run = 1'b0;
    end else begin
      cnt = P - (t % (P + 1)); to = (t >= P + 1); run = 1'b1;
    end
  endfunction

  initial begin
    logic [31:0] d;
    int e0, ch, P, p, w, cnt;
    bit cont, ito, to, run;

    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    #2;
    check("rst_readdata", readdata, 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_vec", 32'(irq_vector), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle();

    for (int c = 0; c < NCH; c++) begin
      rd(c, 0, d); check("rst_status", d, 0);
      rd(c, 1, d); check("rst_control", d, 0);
      rd(c, 2, d); check("rst_period", d, 49999);
      rd(c, 3, d); check("rst_count", d, 49999);
    end

    // ch1 one-shot, PRESC 0
    wr(1, 2, 4); wr(1, 1, 32'h5); e0 = cyc;
    for (int k = 0; k < 6; k++) begin
      rd(1, 3, d); check("ch1_count", d, (k < 5) ? 4 - k : 4);
    end
    rd(1, 0, d); check("ch1_status", d, 32'h1);
    check("ch1_vec", 32'(irq_vector), 32'h2);
    check("ch1_irq", 32'(irq), 1);
    rd(1, 1, d); check("ch1_control", d, 32'h5);
    wr(1, 0, 0);
    check("ch1_vec_clr", 32'(irq_vector), 0);

    // ch0 continuous, PRESC 3, PERIOD 2 -> timeout every 12 cycles
    wr(0, 2, 2); wr(0, 1, 32'h306); e0 = cyc;
    wait_until(e0 + 11);
    rd(0, 0, d); check("ch0_pre_to", d, 32'h2);
    rd(0, 0, d); check("ch0_to", d, 32'h3);
    wr(0, 0, 0);
    rd(0, 0, d); check("ch0_clr", d, 32'h2);
    wait_until(e0 + 23);
    rd(0, 0, d); check("ch0_pre_to2", d, 32'h2);
    rd(0, 0, d); check("ch0_to2", d, 32'h3);
    wr(0, 1, 32'h8); wr(0, 0, 0);

    // ch2 PERIOD rewrite mid-count
    wr(2, 2, 10); wr(2, 1, 32'h4); e0 = cyc;
    wait_until(e0 + 5);
    wr(2, 2, 7);
    rd(2, 3, d); check("ch2_reload", d, 7);
    rd(2, 0, d); check("ch2_status", d, 0);
    repeat (15) idle();
    rd(2, 0, d); check("ch2_no_to", d, 0);

    // ch3 clear racing a timeout, then START+STOP
    wr(3, 2, 3); wr(3, 1, 32'h7); e0 = cyc;
    wait_until(e0 + 5);
    rd(3, 0, d); check("ch3_to", d, 32'h3);
    check("ch3_vec", 32'(irq_vector), 32'h8);
    wait_until(e0 + 7);
    wr(3, 0, 0);
    rd(3, 0, d); check("ch3_clr_race", d, 32'h2);
    wr(3, 1, 32'h8);
    rd(3, 0, d); check("ch3_stop", d, 0);
    wr(3, 1, 32'hC);
    rd(3, 0, d); check("ch3_startstop", d, 32'h2);
    rd(3, 1, d); check("ch3_ctrl_rb", d, 32'hC);
    wr(3, 1, 32'h8); wr(3, 0, 0);

    // combined irq with two channels pending
    wr(0, 2, 2); wr(0, 1, 32'h7); wr(3, 2, 2); wr(3, 1, 32'h7);
    repeat (8) idle();
    wr(0, 1, 32'h9); wr(3, 1, 32'h9);
    check("both_vec", 32'(irq_vector), 32'h9);
    wr(0, 0, 0);
    check("ch3_only_vec", 32'(irq_vector), 32'h8);
    check("ch3_only_irq", 32'(irq), 1);
    wr(3, 0, 0);
    check("none_vec", 32'(irq_vector), 0);
    check("none_irq", 32'(irq), 0);

    // asynchronous reset mid-count
    wr(3, 2, 2); wr(3, 1, 32'h7);
    repeat (5) idle();
    check("pre_rst_irq", 32'(irq), 1);
    #3 reset = 1'b1;
    #1;
    check("arst_irq", 32'(irq), 0);
    check("arst_vec", 32'(irq_vector), 0);
    check("arst_readdata", readdata, 0);
    @(posedge clk); #1 reset = 1'b0;
    rd(3, 3, d); check("arst_count", d, 49999);
    rd(3, 0, d); check("arst_status", d, 0);
    rd(3, 1, d); check("arst_control", d, 0);

    // randomized single-channel runs against the closed-form model
    for (int it = 0; it < 24; it++) begin
      ch   = $urandom_range(0, NCH - 1);
      P    = $urandom_range(1, 20);
      p    = $urandom_range(0, 3);
      w    = $urandom_range(0, 90);
      cont = 1'($urandom_range(0, 1));
      ito  = 1'($urandom_range(0, 1));
      wr(ch, 2, 32'(P));
      wr(ch, 1, 32'((p << 8) | 4 | (int'(cont) << 1) | int'(ito)));
      e0 = cyc;
      repeat (w) idle();
      model(P, p, cont, cyc - e0, cnt, to, run);
      rd(ch, 3, d); check("rnd_count", d, 32'(cnt));
      model(P, p, cont, cyc - e0, cnt, to, run);
      rd(ch, 0, d); check("rnd_status", d, {30'd0, run, to});
      model(P, p, cont, cyc - e0, cnt, to, run);
      check("rnd_vec", 32'(irq_vector), (to && ito) ? (32'h1 << ch) : 32'h0);
      wr(ch, 1, 32'h8); wr(ch, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
